// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with flip-flop storage.
// Hits return in the same cycle; a miss fills one 256-bit line per pmem handshake.
module icache_dm #(
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 5,
    parameter int S_TAG    = 32 - S_OFFSET - S_INDEX
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int N_SETS = 1 << S_INDEX;
    localparam int WORD_W = S_OFFSET - 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [N_SETS-1:0]     valid_q, valid_d;
    logic [S_TAG-1:0]      tag_q [N_SETS];
    logic [255:0]          data_q [N_SETS];
    logic [31-S_OFFSET:0]  fill_line_q, fill_line_d;

    logic [S_TAG-1:0]      req_tag_s;
    logic [S_INDEX-1:0]    req_idx_s;
    logic [WORD_W-1:0]     req_word_s;
    logic [S_INDEX-1:0]    fill_idx_s;
    logic [S_TAG-1:0]      fill_tag_s;
    logic                  hit_s;
    logic                  fill_we_s;
    logic                  unused_s;

    assign req_tag_s  = mem_address[31 -: S_TAG];
    assign req_idx_s  = mem_address[S_OFFSET +: S_INDEX];
    assign req_word_s = mem_address[2 +: WORD_W];
    assign fill_idx_s = fill_line_q[0 +: S_INDEX];
    assign fill_tag_s = fill_line_q[S_INDEX +: S_TAG];
    // Fetches are word aligned, so the two low address bits carry no information.
    assign unused_s   = ^mem_address[1:0];

    // Lookup and response path, all combinational from registered state.
    always_comb begin
        hit_s     = mem_read & valid_q[req_idx_s] & (tag_q[req_idx_s] == req_tag_s);
        mem_resp  = (state_q == ST_IDLE) & hit_s;
        mem_rdata = 32'd0;
        if (valid_q[req_idx_s]) begin
            mem_rdata = data_q[req_idx_s][32*req_word_s +: 32];
        end else begin
            mem_rdata = 32'd0;
        end
        pmem_read    = (state_q == ST_FILL);
        pmem_address = 32'd0;
        if (state_q == ST_FILL) begin
            pmem_address = {fill_line_q, {S_OFFSET{1'b0}}};
        end else begin
            pmem_address = 32'd0;
        end
    end

    // Next-state logic for the miss/fill controller.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        fill_line_d = fill_line_q;
        fill_we_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_read & ~hit_s) begin
                    fill_line_d = mem_address[31:S_OFFSET];
                    state_d     = ST_FILL;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (pmem_resp) begin
                    fill_we_s           = 1'b1;
                    valid_d[fill_idx_s] = 1'b1;
                    state_d             = ST_IDLE;
                end else begin
                    state_d             = ST_FILL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state; reset abandons any fill in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            valid_q     <= '0;
            fill_line_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            fill_line_q <= fill_line_d;
        end
    end

    // Tag/data arrays are not cleared; valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (rst && fill_we_s) begin
            data_q[fill_idx_s] <= pmem_rdata;
            tag_q[fill_idx_s]  <= fill_tag_s;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed vector table, a reset-mid-fill
// sequence, and randomized traffic against a line-residency reference model.
module tb_icache_dm;

    logic         clk;
    logic         rst;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int checks   = 0;
    int failures = 0;

    icache_dm dut (
        .clk          (clk),
        .rst          (rst),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mr;
        logic [31:0] addr;
        logic        presp;
        logic [31:0] line;
        logic        e_resp;
        logic [31:0] e_rdata;
        logic        e_pread;
        logic [31:0] e_paddr;
    } vec_t;

    vec_t vecs[$];

    // Backing memory contents: a fixed pattern, with the instruction at 0x6C pinned.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_006C) return 32'h00A0_0093;
        return (a * 32'h0100_0193) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        logic [255:0] l;
        logic [31:0]  base;
        base = a & 32'hFFFF_FFE0;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = mem_word(base + 32'(4*w));
        return l;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; mem_read = 1'b0; pmem_resp = 1'b0; mem_address = 32'd0;
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic add(input logic mr, input logic [31:0] addr, input logic presp,
                       input logic [31:0] line, input logic e_resp, input logic [31:0] e_rdata,
                       input logic e_pread, input logic [31:0] e_paddr);
        vec_t v;
        v.mr = mr; v.addr = addr; v.presp = presp; v.line = line;
        v.e_resp = e_resp; v.e_rdata = e_rdata; v.e_pread = e_pread; v.e_paddr = e_paddr;
        vecs.push_back(v);
    endtask

    // Random-phase reference model: which line address each set holds.
    logic        m_valid [8];
    logic [31:0] m_res   [8];
    logic        m_fill;
    logic [31:0] m_faddr;
    int          lat;

    initial begin
        logic [31:0] cur_addr;
        logic        got;
        logic [2:0]  ix;
        logic        e_hit;

        pmem_rdata = '0;
        // Cold miss 0x60: fill requested next cycle, line returned on the 5th cycle.
        add(1'b0, 32'h60,  1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0);
        add(1'b1, 32'h60,  1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++)
            add(1'b1, 32'h60, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h60);
        add(1'b1, 32'h60,  1'b1, 32'h60,  1'b0, 32'h0, 1'b1, 32'h60);
        add(1'b1, 32'h6C,  1'b0, 32'h0,   1'b1, 32'h00A0_0093, 1'b0, 32'h0);
        for (int k = 0; k < 8; k++)
            add(1'b1, 32'h60 + 32'(4*k), 1'b0, 32'h0, 1'b1, mem_word(32'h60 + 32'(4*k)), 1'b0, 32'h0);
        // Conflict eviction by 0x160, then 0x60 misses again.
        add(1'b1, 32'h160, 1'b0, 32'h0,   1'b0, mem_word(32'h60), 1'b0, 32'h0);
        add(1'b1, 32'h160, 1'b1, 32'h160, 1'b0, mem_word(32'h60), 1'b1, 32'h160);
        add(1'b1, 32'h164, 1'b0, 32'h0,   1'b1, mem_word(32'h164), 1'b0, 32'h0);
        add(1'b1, 32'h60,  1'b0, 32'h0,   1'b0, mem_word(32'h160), 1'b0, 32'h0);
        add(1'b1, 32'h60,  1'b1, 32'h60,  1'b0, mem_word(32'h160), 1'b1, 32'h60);
        add(1'b1, 32'h60,  1'b0, 32'h0,   1'b1, mem_word(32'h60), 1'b0, 32'h0);
        // Idle with a stray pmem_resp: nothing changes.
        for (int k = 0; k < 10; k++)
            add(1'b0, (k % 2 == 0) ? 32'h60 : 32'h80, (k == 3) ? 1'b1 : 1'b0, 32'h80,
                1'b0, (k % 2 == 0) ? mem_word(32'h60) : 32'h0, 1'b0, 32'h0);
        add(1'b1, 32'h60,  1'b0, 32'h0,   1'b1, mem_word(32'h60), 1'b0, 32'h0);
        add(1'b1, 32'h80,  1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0);
        add(1'b1, 32'h80,  1'b1, 32'h80,  1'b0, 32'h0, 1'b1, 32'h80);
        // Address change during a fill: 0xA0 still installs, then 0x200 fills.
        add(1'b1, 32'hA0,  1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0);
        add(1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 32'hA0);
        add(1'b1, 32'h200, 1'b1, 32'hA0,  1'b0, 32'h0, 1'b1, 32'hA0);
        add(1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0);
        add(1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200);
        add(1'b1, 32'h200, 1'b0, 32'h0,   1'b1, mem_word(32'h200), 1'b0, 32'h0);
        add(1'b1, 32'hA8,  1'b0, 32'h0,   1'b1, mem_word(32'hA8), 1'b0, 32'h0);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            mem_read    = vecs[i].mr;
            mem_address = vecs[i].addr;
            pmem_resp   = vecs[i].presp;
            pmem_rdata  = mem_line(vecs[i].line);
            #4;
            check($sformatf("vec%0d mem_resp", i),     {31'd0, mem_resp},  {31'd0, vecs[i].e_resp});
            check($sformatf("vec%0d mem_rdata", i),    mem_rdata,          vecs[i].e_rdata);
            check($sformatf("vec%0d pmem_read", i),    {31'd0, pmem_read}, {31'd0, vecs[i].e_pread});
            check($sformatf("vec%0d pmem_address", i), pmem_address,       vecs[i].e_paddr);
            tick();
        end

        // Reset during a fill, with the abandoned response arriving later.
        pmem_resp = 1'b0; mem_read = 1'b1; mem_address = 32'h300;
        #4; check("rmf miss resp", {31'd0, mem_resp}, 32'd0);
        tick();
        #4; check("rmf fill pread", {31'd0, pmem_read}, 32'd1);
        check("rmf fill paddr", pmem_address, 32'h300);
        rst = 1'b0;
        tick();
        rst = 1'b1; mem_read = 1'b0;
        #4; check("rmf post-reset pread", {31'd0, pmem_read}, 32'd0);
        check("rmf post-reset rdata", mem_rdata, 32'd0);
        tick();
        pmem_resp = 1'b1; pmem_rdata = mem_line(32'h300);
        tick();
        pmem_resp = 1'b0; mem_read = 1'b1; mem_address = 32'h300;
        #4; check("rmf late resp no write resp", {31'd0, mem_resp}, 32'd0);
        check("rmf late resp no write rdata", mem_rdata, 32'd0);
        tick();
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (!got) begin
                if (pmem_read === 1'b1) got = 1'b1;
                else tick();
            end
        end
        check("rmf refill started", {31'd0, got}, 32'd1);
        check("rmf refill paddr", pmem_address, 32'h300);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        #4; check("rmf refill hit resp", {31'd0, mem_resp}, 32'd1);
        check("rmf refill hit rdata", mem_rdata, mem_word(32'h300));
        tick();

        // Randomized traffic against the residency model.
        do_reset();
        for (int s = 0; s < 8; s++) begin m_valid[s] = 1'b0; m_res[s] = 32'd0; end
        m_fill = 1'b0; m_faddr = 32'd0; lat = 0;
        cur_addr = 32'h60;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 3) == 0)
                cur_addr = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 5)
                         | (32'($urandom_range(0, 7)) << 2);
            mem_address = cur_addr;
            mem_read    = ($urandom_range(0, 4) != 0);
            if (m_fill) begin
                if (lat == 0) begin
                    pmem_resp = 1'b1; pmem_rdata = mem_line(m_faddr);
                end else begin
                    pmem_resp = 1'b0; lat--;
                end
            end else begin
                pmem_resp  = ($urandom_range(0, 15) == 0);
                pmem_rdata = {$urandom, $urandom, $urandom, $urandom,
                              $urandom, $urandom, $urandom, $urandom};
            end
            ix    = cur_addr[7:5];
            e_hit = mem_read && !m_fill && m_valid[ix] && (m_res[ix] == (cur_addr & 32'hFFFF_FFE0));
            #4;
            check($sformatf("rnd%0d mem_resp", cyc),     {31'd0, mem_resp},  {31'd0, e_hit});
            check($sformatf("rnd%0d pmem_read", cyc),    {31'd0, pmem_read}, {31'd0, m_fill});
            check($sformatf("rnd%0d pmem_address", cyc), pmem_address,       m_fill ? m_faddr : 32'd0);
            if (!m_fill)
                check($sformatf("rnd%0d mem_rdata", cyc), mem_rdata,
                      m_valid[ix] ? mem_word(m_res[ix] + (cur_addr & 32'h1C)) : 32'd0);
            tick();
            if (!rst) begin
                m_fill = 1'b0;
                for (int s = 0; s < 8; s++) m_valid[s] = 1'b0;
            end else if (m_fill) begin
                if (pmem_resp) begin
                    m_valid[m_faddr[7:5]] = 1'b1;
                    m_res[m_faddr[7:5]]   = m_faddr;
                    m_fill = 1'b0;
                end
            end else if (mem_read && !e_hit) begin
                m_fill  = 1'b1;
                m_faddr = cur_addr & 32'hFFFF_FFE0;
                lat     = $urandom_range(0, 4);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
